// File: rtl/midilib_dbg_pkg.sv
// rtl/midilib_dbg_pkg.sv - shared types, default parameters and helpers for the debug command synchroniser
package midilib_dbg_pkg;

    localparam int DEF_DATA_W      = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Widest one-hot the helper can produce; callers truncate to their channel count.
    localparam int ONEHOT_W = 256;

    typedef struct packed {
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_DATA_W-1:0] data;
    } cmd_t;

    function automatic logic [ONEHOT_W-1:0] onehot(input logic [7:0] idx);
        return ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/midilib_dbg_toggle_sync.sv
// rtl/midilib_dbg_toggle_sync.sv - toggle synchroniser with delay flop and gated edge detect
// ports: clk, reset (async, active high), din (async toggle), en (edge enable), toggled (edge, combinational)
module midilib_dbg_toggle_sync
    import midilib_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic toggled
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    // The delay flop keeps tracking while en is low, so a level held across
    // reset is absorbed during warm-up instead of reported as an edge.
    assign toggled = en & (sync[SYNC_STAGES-1] ^ dly);

endmodule

// File: rtl/midilib_dbg_cmd_sync.sv
// rtl/midilib_dbg_cmd_sync.sv - JTAG update-DR/IR command crossing into clk with a command FIFO
// ports: clk, reset (async, active high); udr_tgl, uir_tgl, ir_in, sr (JTAG side);
//        cmd_valid/cmd_ready, jdo, cmd_ir (FIFO head); take_action, take_no_action (one-hot pop strobes);
//        ir_update (update-IR pulse); overflow (sticky drop); level (occupancy); parity_err (drop pulse)
// option: MIDILIB_DBG_PARITY_EN drops odd-parity sr words and pulses parity_err
module midilib_dbg_cmd_sync
    import midilib_dbg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   udr_tgl,
    input  logic                   uir_tgl,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [DATA_W-1:0]      sr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [DATA_W-1:0]      jdo,
    output logic [IR_W-1:0]        cmd_ir,
    output logic [(2**IR_W)-1:0]   take_action,
    output logic [(2**IR_W)-1:0]   take_no_action,
    output logic                   ir_update,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic                   parity_err
);

    localparam int NCH = 2**IR_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WW  = $clog2(SYNC_STAGES + 2);
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [WW-1:0]  warm_cnt;
    logic           armed;
    logic           udr_edge;
    logic           uir_edge;
    logic           push_ok;
    logic           push;
    logic           pop;
    logic           full;
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    entry_t         mem [DEPTH];
    entry_t         head;
    logic [NCH-1:0] head_sel;

    // Edge detection stays off until the synchronisers and delay flops have
    // settled on whatever level the toggles held at reset release.
    assign armed = (warm_cnt == WARM_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!armed) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    midilib_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (udr_tgl),
        .en      (armed),
        .toggled (udr_edge)
    );

    midilib_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (uir_tgl),
        .en      (armed),
        .toggled (uir_edge)
    );

`ifdef MIDILIB_DBG_PARITY_EN
    logic par_bad;

    assign par_bad = ^sr;
    assign push_ok = udr_edge & ~par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= udr_edge & par_bad;
        end
    end
`else
    assign push_ok    = udr_edge;
    assign parity_err = 1'b0;
`endif

    assign level = wptr - rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = cmd_valid & cmd_ready;
    // A pop in the same cycle frees the slot the full FIFO would otherwise refuse.
    assign push  = push_ok & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
            ir_update <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            // Occupancy before this edge's push, minus this cycle's pop: a new
            // word shows one cycle after it lands, a consumed one leaves at once.
            cmd_valid <= (level != PW'(pop));
            if (push_ok & full & ~pop) begin
                overflow <= 1'b1;
            end
            ir_update <= uir_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= '{ir: ir_in, data: sr};
        end
    end

    assign head     = mem[rptr[AW-1:0]];
    assign jdo      = cmd_valid ? head.data : '0;
    assign cmd_ir   = cmd_valid ? head.ir : '0;
    assign head_sel = NCH'(onehot(8'(cmd_ir)));

    assign take_action    = (pop &&  jdo[DATA_W-1]) ? head_sel : '0;
    assign take_no_action = (pop && !jdo[DATA_W-1]) ? head_sel : '0;

endmodule

// File: doc/midilib_dbg_cmd_sync.md
MIDILIB_DBG_CMD_SYNC -- requirements
Module: midilib_dbg_cmd_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 38, width of the captured debug data word (jdo).
REQ-002 SHALL have parameter IR_W, default 2, instruction-register width; the action channel count is NCH = 2**IR_W.
REQ-003 SHALL have parameter DEPTH, default 4, command FIFO depth, a power of two, at least 2.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser flop count, at least 2.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: system clock; all state is on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port udr_tgl, input, 1 bit: toggles once per JTAG update-DR; asynchronous to clk.
REQ-009 Port uir_tgl, input, 1 bit: toggles once per JTAG update-IR; asynchronous to clk.
REQ-010 Port ir_in, input, IR_W bits: instruction register; stable from a udr_tgl change until the next shift.
REQ-011 Port sr, input, DATA_W bits: shift-register contents; same stability rule as ir_in.
REQ-012 Port cmd_valid, output, 1 bit: FIFO head is valid.
REQ-013 Port cmd_ready, input, 1 bit: consumer accepts the head.
REQ-014 Port jdo, output, DATA_W bits: head data word.
REQ-015 Port cmd_ir, output, IR_W bits: head instruction.
REQ-016 Port take_action, output, NCH bits: one-hot action strobe.
REQ-017 Port take_no_action, output, NCH bits: one-hot no-action strobe.
REQ-018 Port ir_update, output, 1 bit: one-cycle pulse per update-IR.
REQ-019 Port overflow, output, 1 bit: sticky flag; a command was dropped because the FIFO was full.
REQ-020 Port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-021 Port parity_err, output, 1 bit: one-cycle pulse; a word was dropped on parity.

Function
REQ-022 Each toggle SHALL pass through SYNC_STAGES flops plus one delay flop; an edge is the XOR of the last stage and the delay flop.
REQ-023 A udr edge SHALL push {ir_in, sr} on the following rising edge; cmd_valid SHALL rise SYNC_STAGES+1 edges after the first edge that samples the new toggle level.
REQ-024 A uir edge SHALL pulse ir_update for exactly one cycle; it SHALL NOT touch the FIFO.
REQ-025 cmd_valid SHALL equal FIFO non-empty, registered; jdo and cmd_ir SHALL present the head entry; a pop occurs when cmd_valid and cmd_ready are both high.
REQ-026 On a pop, take_action[cmd_ir] SHALL be high that cycle if jdo[DATA_W-1]=1, otherwise take_no_action[cmd_ir]; all other bits SHALL be 0.
REQ-027 Push when full with no pop: the word is dropped, level is unchanged, and overflow is set until reset.
REQ-028 Push when full with a simultaneous pop: both SHALL complete and level stays DEPTH.
REQ-029 Push when empty with cmd_ready high: no same-cycle bypass; the word is popped at the earliest one cycle later.
REQ-030 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL be derived from MSB comparison.

Reset
REQ-031 Reset SHALL clear synchroniser, delay flops, pointers and overflow to 0; every output SHALL be 0.
REQ-032 For SYNC_STAGES+1 cycles after reset deassertion, a warm-up counter SHALL suppress edge detection while the delay flops track; a toggle held at 1 through reset SHALL NOT create a command.
REQ-033 Reset asserted mid-operation SHALL discard FIFO contents immediately.

Configuration
REQ-034 With MIDILIB_DBG_PARITY_EN defined, a pushed word whose sr has odd XOR-parity SHALL be dropped and parity_err SHALL pulse for one cycle; the drop does not set overflow.
REQ-035 Without MIDILIB_DBG_PARITY_EN, parity_err SHALL be tied 0 and no parity logic SHALL exist.

Structure
REQ-036 Package midilib_dbg_pkg SHALL hold the cmd typedef {ir, data}, the default parameter constants, and a onehot function.
REQ-037 Sub-module midilib_dbg_toggle_sync SHALL implement the synchroniser, delay flop and edge detect; it is instantiated twice.

Verification
REQ-038 udr_tgl 0->1 with ir_in=2, sr[37]=1, cmd_ready=1: cmd_valid rises 3 edges later, then take_action=4'b0100 for one cycle, and level returns to 0.
REQ-039 Five udr toggles with cmd_ready=0 and DEPTH=4: level=4, overflow=1, and the first four words pop in order.
REQ-040 Full FIFO, a push and a pop in the same cycle: level stays 4, overflow stays 0.
REQ-041 udr_tgl=1 held through reset release: no cmd_valid for 10 cycles.
REQ-042 With the macro defined, sr with odd parity: parity_err pulses once and level stays 0; the next even-parity word is accepted.
REQ-043 uir_tgl toggle: ir_update pulses once and level is unchanged.
